seq_11011_tx: RTL and testbench
===============================

# seq_11011_tx

Serial pattern transmitter, the sending end of the 11011 overlapping-sequence detector. On a start request it drives a programmable number of occurrences of a fixed bit pattern (default 11011) onto a single serial line, one bit per clock, MSB first. Occurrences are sent either back-to-back or overlapped, where consecutive occurrences share their common prefix/suffix bits. Its serial output connects directly to the detector's `inp_1` input, and it doubles as the self-checking stimulus source for the detector.

## Interface
Parameters:
- PATTERN, 5'b11011, bit pattern to transmit; bit LEN-1 is sent first
- LEN, 5, pattern length in bits (2..8)
- OVL, 2, number of bits shared between consecutive occurrences in overlap mode; must satisfy 0 <= OVL < LEN
- CNT_W, 4, width of occurrence count

Ports:
- input_pulse  in  1  clock; all state updates on its rising edge
- clear  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- count  in  CNT_W  number of occurrences; latched with start
- overlap  in  1  1 = overlapped mode, 0 = back-to-back; latched with start
- abort  in  1  synchronous cancel of an in-progress transmission
- inp_1  out  1  serial data line, registered
- valid  out  1  high while inp_1 carries a pattern bit
- occ_end  out  1  high in the cycle inp_1 carries the last bit of an occurrence
- busy  out  1  high in SEND and DONE
- done  out  1  one-cycle pulse after normal completion
- present_state  out  3  current FSM state code

## Operation
- States, with present_state codes: IDLE = 3'd0, SEND = 3'd1, DONE = 3'd2. Codes 3..7 are unused and recover to IDLE on the next edge.
- Internal registers: bit index idx, remaining-occurrence counter rem (CNT_W bits), latched overlap flag.
- IDLE:
  - inp_1 = 0, valid = 0.
  - When start = 1 and count != 0: latch count into rem and latch overlap, set idx = LEN-1, go to SEND.
  - When start = 1 and count = 0: ignored, stay in IDLE.
- SEND:
  - Each cycle, inp_1 = PATTERN[idx] and valid = 1.
  - occ_end = 1 when idx = 0.
  - If idx > 0: idx decrements.
  - If idx = 0 and rem > 1: rem decrements. idx reloads to LEN-1 in back-to-back mode, or to LEN-1-OVL in overlap mode.
  - If idx = 0 and rem = 1: go to DONE.
- DONE: one cycle with done = 1, inp_1 = 0, valid = 0, then go to IDLE.
- Total bits per request:
  - Back-to-back: count×LEN.
  - Overlap: LEN + (count−1)×(LEN−OVL).
- abort = 1 in SEND: next state is IDLE with inp_1 = 0, and no done pulse. abort in IDLE or DONE has no effect.
- start while busy is ignored, and count and overlap changes while busy are ignored.
- Simultaneous start and abort in IDLE: start wins, and abort is ignored.

## Timing
- Reset (clear = 0) takes effect immediately, independent of input_pulse. State goes to IDLE; inp_1, valid, occ_end, busy and done all go to 0; present_state = 0; idx and rem are cleared.
- All outputs are registered, or decoded from registered state only.
- Latency: start sampled at edge N puts the first pattern bit on inp_1 after edge N, so it is valid for the whole cycle N..N+1. Bit k of the stream is on the line after edge N+k.
- done pulses in the cycle after the last bit. The earliest accepted restart is the start sampled in the cycle following DONE. A start asserted during DONE is ignored.
- inp_1 changes only just after rising edges, giving a full clock period of setup for a rising-edge sampler.
- rem never wraps: the maximum count of 2^CNT_W−1 is sent in full.

## Test plan
- Reset: assert clear = 0 asynchronously mid-SEND (bit 3) -> all outputs 0 and present_state = 0 immediately, before the next edge; no done pulse.
- count = 1, overlap = 0 -> inp_1 = 1,1,0,1,1 on cycles 1–5 after the start edge; occ_end on cycle 5; done on cycle 6; present_state 0 on cycle 7.
- count = 2, overlap = 1 -> 8 bits 1,1,0,1,1,0,1,1; occ_end on bits 5 and 8; done on cycle 9.
- count = 2, overlap = 0 -> 10 bits 1101111011; occ_end on bits 5 and 10; valid high for exactly 10 cycles.
- Control corner cases:
  - count = 0 with start -> no activity.
  - start re-asserted during SEND -> ignored, stream unaltered.
  - abort at bit 3 -> IDLE next cycle, inp_1 = 0, no done.
- Loopback: drive fsm_11011's inp_1 from this block's output, with count = 3, overlap = 1 -> 11 bits 11011011011; detector out asserted exactly 3 times, each aligned to occ_end (bits 5, 8, 11).

Source files
------------

// File: rtl/seq_11011_tx.sv
// Serial pattern transmitter: sends `count` occurrences of PATTERN MSB-first, back-to-back or overlapped.
// First bit is on inp_1 right after the edge that samples start; there is no backpressure.
module seq_11011_tx #(
  parameter int              LEN     = 5,
  parameter logic [LEN-1:0]  PATTERN = 5'b11011,
  parameter int              OVL     = 2,
  parameter int              CNT_W   = 4
) (
  input  logic             input_pulse,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             overlap,
  input  logic             abort,
  output logic             inp_1,
  output logic             valid,
  output logic             occ_end,
  output logic             busy,
  output logic             done,
  output logic [2:0]       present_state
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(LEN - 1);
  localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(LEN - 1 - OVL);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    DONE = 3'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             ovl_q, ovl_n;
  logic             inp_1_n, valid_n, occ_end_n;

  always_ff @(posedge input_pulse or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      idx     <= '0;
      rem     <= '0;
      ovl_q   <= 1'b0;
      inp_1   <= 1'b0;
      valid   <= 1'b0;
      occ_end <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      rem     <= rem_n;
      ovl_q   <= ovl_n;
      inp_1   <= inp_1_n;
      valid   <= valid_n;
      occ_end <= occ_end_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    rem_n   = rem;
    ovl_n   = ovl_q;
    case (state)
      IDLE: begin
        if (start && (count != '0)) begin
          rem_n   = count;
          ovl_n   = overlap;
          idx_n   = IDX_FULL;
          state_n = SEND;
        end
      end
      SEND: begin
        // Abort takes priority, including over the final bit's move to DONE.
        if (abort) begin
          state_n = IDLE;
        end else if (idx != '0) begin
          idx_n = idx - 1'b1;
        end else if (rem > CNT_W'(1)) begin
          rem_n = rem - 1'b1;
          idx_n = ovl_q ? IDX_OVL : IDX_FULL;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Line outputs are registered from the next-state view so they change only at edges.
    valid_n   = (state_n == SEND);
    inp_1_n   = valid_n ? PATTERN[idx_n] : 1'b0;
    occ_end_n = valid_n && (idx_n == '0);
  end

  assign busy          = (state == SEND) || (state == DONE);
  assign done          = (state == DONE);
  assign present_state = state;

endmodule

// File: tb/tb_seq_11011_tx.sv
// Directed self-checking bench for seq_11011_tx with a behavioural 11011 detector for loopback.
module tb_seq_11011_tx;

  logic       input_pulse = 1'b0;
  logic       clear;
  logic       start;
  logic [3:0] count;
  logic       overlap;
  logic       abort;
  logic       inp_1, valid, occ_end, busy, done;
  logic [2:0] present_state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_11011_tx dut (
    .input_pulse   (input_pulse),
    .clear         (clear),
    .start         (start),
    .count         (count),
    .overlap       (overlap),
    .abort         (abort),
    .inp_1         (inp_1),
    .valid         (valid),
    .occ_end       (occ_end),
    .busy          (busy),
    .done          (done),
    .present_state (present_state)
  );

  always #5 input_pulse = ~input_pulse;

  task automatic tick();
    @(posedge input_pulse);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; count = '0; overlap = 1'b0; abort = 1'b0;
    #2;
    n_checks++;
    if ({inp_1, valid, occ_end, busy, done, present_state} !== 8'd0) begin
      n_fail++; $display("FAIL reset_init: got %b expected 00000000", {inp_1, valid, occ_end, busy, done, present_state});
    end
    clear = 1'b1;
    tick();
    start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0;
    tick(); tick();
    // bit 3 (index 2 of the stream) is on the line now
    n_checks++;
    if (present_state !== 3'd1 || inp_1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_pre: got ps=%0d inp_1=%b expected ps=1 inp_1=0", present_state, inp_1);
    end
    #3 clear = 1'b0;
    #1;
    n_checks++;
    if ({inp_1, valid, occ_end, busy, done, present_state} !== 8'd0) begin
      n_fail++; $display("FAIL reset_async: got %b expected 00000000", {inp_1, valid, occ_end, busy, done, present_state});
    end
    #2 clear = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || present_state !== 3'd0) begin
        n_fail++; $display("FAIL reset_no_done: cycle %0d got done=%b ps=%0d expected 0 0", c, done, present_state);
      end
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_b = 5'b11011;
    logic [4:0] exp_o = 5'b00001;
    start = 1'b1; count = 4'd1; overlap = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (inp_1 !== exp_b[4-k] || valid !== 1'b1 || occ_end !== exp_o[4-k] || busy !== 1'b1 || present_state !== 3'd1) begin
        n_fail++; $display("FAIL single_bit%0d: got inp_1=%b valid=%b occ_end=%b busy=%b ps=%0d expected %b 1 %b 1 1",
                           k + 1, inp_1, valid, occ_end, busy, present_state, exp_b[4-k], exp_o[4-k]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0 || inp_1 !== 1'b0 || present_state !== 3'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_done: got done=%b valid=%b inp_1=%b ps=%0d busy=%b expected 1 0 0 2 1", done, valid, inp_1, present_state, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || present_state !== 3'd0) begin
      n_fail++; $display("FAIL single_idle: got done=%b busy=%b ps=%0d expected 0 0 0", done, busy, present_state);
    end
  endtask

  task automatic test_overlap2();
    logic [7:0] exp_b = 8'b11011011;
    logic [7:0] exp_o = 8'b00001001;
    start = 1'b1; count = 4'd2; overlap = 1'b1;
    tick();
    start = 1'b0; count = 4'd9; overlap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (inp_1 !== exp_b[7-k] || valid !== 1'b1 || occ_end !== exp_o[7-k]) begin
        n_fail++; $display("FAIL ovl2_bit%0d: got inp_1=%b valid=%b occ_end=%b expected %b 1 %b", k + 1, inp_1, valid, occ_end, exp_b[7-k], exp_o[7-k]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL ovl2_done: got done=%b valid=%b expected 1 0", done, valid);
    end
    tick();
  endtask

  task automatic test_b2b2();
    logic [9:0] exp_b = 10'b1101111011;
    logic [9:0] exp_o = 10'b0000100001;
    int vcnt = 0;
    start = 1'b1; count = 4'd2; overlap = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (valid === 1'b1) vcnt++;
      n_checks++;
      if (inp_1 !== exp_b[9-k] || occ_end !== exp_o[9-k]) begin
        n_fail++; $display("FAIL b2b2_bit%0d: got inp_1=%b occ_end=%b expected %b %b", k + 1, inp_1, occ_end, exp_b[9-k], exp_o[9-k]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL b2b2_done: got %b expected 1", done);
    end
    for (int k = 0; k < 4; k++) begin
      if (valid === 1'b1) vcnt++;
      tick();
    end
    n_checks++;
    if (vcnt != 10) begin
      n_fail++; $display("FAIL b2b2_valid_len: got %0d expected 10", vcnt);
    end
  endtask

  task automatic test_count_zero();
    start = 1'b1; count = 4'd0; overlap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (present_state !== 3'd0 || valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL count_zero: got ps=%0d valid=%b busy=%b expected 0 0 0", present_state, valid, busy);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_start_during_send();
    logic [4:0] exp_b = 5'b11011;
    start = 1'b1; count = 4'd1; overlap = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin start = 1'b1; count = 4'd5; overlap = 1'b1; end
      if (k == 3) start = 1'b0;
      n_checks++;
      if (inp_1 !== exp_b[4-k] || valid !== 1'b1) begin
        n_fail++; $display("FAIL restart_send_bit%0d: got inp_1=%b valid=%b expected %b 1", k + 1, inp_1, valid, exp_b[4-k]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL restart_send_done: got %b expected 1", done);
    end
    tick();
    tick();
    n_checks++;
    if (present_state !== 3'd0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_send_idle: got ps=%0d valid=%b expected 0 0", present_state, valid);
    end
  endtask

  task automatic test_restart_timing();
    start = 1'b1; count = 4'd1; overlap = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    // now in DONE; a start held here must be ignored, then accepted from IDLE
    start = 1'b1;
    tick();
    n_checks++;
    if (present_state !== 3'd0) begin
      n_fail++; $display("FAIL start_in_done: got ps=%0d expected 0", present_state);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (present_state !== 3'd1 || inp_1 !== 1'b1) begin
      n_fail++; $display("FAIL start_after_done: got ps=%0d inp_1=%b expected 1 1", present_state, inp_1);
    end
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_abort();
    start = 1'b1; count = 4'd3; overlap = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (present_state !== 3'd0 || inp_1 !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got ps=%0d inp_1=%b valid=%b done=%b busy=%b expected 0 0 0 0 0", present_state, inp_1, valid, done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || present_state !== 3'd0) begin
      n_fail++; $display("FAIL abort_no_done: got done=%b ps=%0d expected 0 0", done, present_state);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; count = 4'd1; overlap = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (present_state !== 3'd1 || valid !== 1'b1) begin
      n_fail++; $display("FAIL start_abort_idle: got ps=%0d valid=%b expected 1 1", present_state, valid);
    end
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_max_count();
    int vcnt = 0;
    int ocnt = 0;
    int saw_done = 0;
    start = 1'b1; count = 4'd15; overlap = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (valid === 1'b1) vcnt++;
      if (occ_end === 1'b1) ocnt++;
      if (done === 1'b1) saw_done++;
      tick();
    end
    n_checks++;
    if (vcnt != 47 || ocnt != 15 || saw_done != 1) begin
      n_fail++; $display("FAIL max_count: got bits=%0d occ=%0d done=%0d expected 47 15 1", vcnt, ocnt, saw_done);
    end
  endtask

  task automatic test_loopback();
    logic [10:0] exp_b = 11'b11011011011;
    logic [4:0]  sh = '0;
    int          det_cnt = 0;
    int          det_at_occ = 0;
    logic        det;
    start = 1'b1; count = 4'd3; overlap = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      sh  = {sh[3:0], inp_1};
      det = (sh == 5'b11011);
      if (det) det_cnt++;
      if (det && occ_end === 1'b1) det_at_occ++;
      if (k < 11) begin
        n_checks++;
        if (inp_1 !== exp_b[10-k]) begin
          n_fail++; $display("FAIL loop_bit%0d: got %b expected %b", k + 1, inp_1, exp_b[10-k]);
        end
      end
      n_checks++;
      if (det !== occ_end) begin
        n_fail++; $display("FAIL loop_align%0d: got occ_end=%b expected %b", k + 1, occ_end, det);
      end
      tick();
    end
    n_checks++;
    if (det_cnt != 3 || det_at_occ != 3) begin
      n_fail++; $display("FAIL loop_detect: got det=%0d aligned=%0d expected 3 3", det_cnt, det_at_occ);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap2();
    test_b2b2();
    test_count_zero();
    test_start_during_send();
    test_restart_timing();
    test_abort();
    test_start_abort_idle();
    test_max_count();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
